// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the trap/redirect controller:
//   - trap_state_e       : controller FSM states (IDLE / DRAIN / VECTOR)
//   - MTVEC_MODE_*       : mtvec[1:0] mode encodings
//   - CAUSE_*            : cause codes used by the pipeline and the bench
//   - MCAUSE_INT_BIT     : interrupt flag position in an RV32 mcause word
//   - mcause_int_bit()   : interrupt flag position for an arbitrary XLEN
// -----------------------------------------------------------------------------
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2
  } trap_state_e;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  localparam int unsigned CAUSE_ILLEGAL_INSTR = 2;
  localparam int unsigned CAUSE_ECALL_M       = 11;
  localparam int unsigned CAUSE_MEXT_IRQ      = 11;

  localparam int MCAUSE_INT_BIT = 31;

  // The interrupt flag is always the MSB of mcause.
  function automatic int mcause_int_bit(input int xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/trap_redirect_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_redirect_ctrl_if
// Bundles every trap-controller signal except clk/rst.
//   Inputs to the controller : exc_valid_M, exc_cause_M, exc_pc_M, mret_M,
//                              irq_pending, irq_cause, mie_global, mtvec,
//                              mepc, resume_pc_M
//   Outputs of the controller: redirect_valid, redirect_pc, stall_F,
//                              flush_D/E/M, mepc_we/wdata, mcause_we/wdata,
//                              trap_enter, trap_exit, busy
// Modports:
//   master : the trap controller (drives redirect, flush and CSR writes)
//   slave  : pipeline / CSR file side
// -----------------------------------------------------------------------------
interface trap_redirect_ctrl_if
  import trap_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
);

  logic               exc_valid_M;
  logic [CAUSE_W-1:0] exc_cause_M;
  logic [XLEN-1:0]    exc_pc_M;
  logic               mret_M;
  logic               irq_pending;
  logic [CAUSE_W-1:0] irq_cause;
  logic               mie_global;
  logic [XLEN-1:0]    mtvec;
  logic [XLEN-1:0]    mepc;
  logic [XLEN-1:0]    resume_pc_M;

  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               stall_F;
  logic               flush_D;
  logic               flush_E;
  logic               flush_M;
  logic               mepc_we;
  logic [XLEN-1:0]    mepc_wdata;
  logic               mcause_we;
  logic [XLEN-1:0]    mcause_wdata;
  logic               trap_enter;
  logic               trap_exit;
  logic               busy;

  modport master (
    input  exc_valid_M, exc_cause_M, exc_pc_M, mret_M,
    input  irq_pending, irq_cause, mie_global, mtvec, mepc, resume_pc_M,
    output redirect_valid, redirect_pc, stall_F, flush_D, flush_E, flush_M,
    output mepc_we, mepc_wdata, mcause_we, mcause_wdata,
    output trap_enter, trap_exit, busy
  );

  modport slave (
    output exc_valid_M, exc_cause_M, exc_pc_M, mret_M,
    output irq_pending, irq_cause, mie_global, mtvec, mepc, resume_pc_M,
    input  redirect_valid, redirect_pc, stall_F, flush_D, flush_E, flush_M,
    input  mepc_we, mepc_wdata, mcause_we, mcause_wdata,
    input  trap_enter, trap_exit, busy
  );

endinterface

// File: rtl/trap_target_calc.sv
// -----------------------------------------------------------------------------
// trap_target_calc
// Combinational trap vector computation from mtvec and a cause code.
// Optional feature macro: VECTORED_TRAP_EN
//   defined   : interrupts with mtvec mode VECTORED go to base + 4*cause
//   undefined : mode bits ignored, every trap goes to the base
// Ports:
//   i_mtvec  in  XLEN     trap vector register (bits [1:0] = mode)
//   i_cause  in  CAUSE_W  cause code (only used for vectored interrupts)
//   i_is_irq in  1        target is for an interrupt (exceptions use base)
//   o_target out XLEN     trap target address
// -----------------------------------------------------------------------------
module trap_target_calc
  import trap_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 5
) (
  input  logic [XLEN-1:0]    i_mtvec,
  input  logic [CAUSE_W-1:0] i_cause,
  input  logic               i_is_irq,
  output logic [XLEN-1:0]    o_target
);

  logic [XLEN-1:0] w_base;
  assign w_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef VECTORED_TRAP_EN
  logic [XLEN-1:0] w_offset;
  // 4*cause, zero-extended to XLEN
  assign w_offset = {{(XLEN-CAUSE_W-2){1'b0}}, i_cause, 2'b00};
  assign o_target = (i_is_irq && (i_mtvec[1:0] == MTVEC_MODE_VECTORED)) ?
                    (w_base + w_offset) : w_base;
`else
  logic w_unused;
  assign w_unused = ^{i_cause, i_is_irq, i_mtvec[1:0]};
  assign o_target = w_base;
`endif

endmodule

// File: rtl/trap_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// trap_redirect_ctrl
// Sequences PC redirects caused by exceptions, external interrupts and MRET,
// writes mepc/mcause and toggles mstatus MIE/MPIE via trap_enter/trap_exit.
// Exceptions and MRET redirect combinationally in the same cycle; interrupts
// are latched, the pipeline is drained for DRAIN_CYCLES cycles, then a single
// VECTOR cycle issues the redirect and CSR writes.
// Optional feature macro: VECTORED_TRAP_EN (see trap_target_calc).
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  trap_redirect_ctrl_if.master (all pipeline / CSR signals)
// Parameters: XLEN, DRAIN_CYCLES (1..7), CAUSE_W
// -----------------------------------------------------------------------------
module trap_redirect_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int CAUSE_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  trap_redirect_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_DRAIN  = ST_DRAIN;
  localparam logic [1:0] S_VECTOR = ST_VECTOR;
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
  localparam int         INT_BIT    = mcause_int_bit(XLEN);

  logic [1:0]         r_state, w_state_next;
  logic [2:0]         r_cnt, w_cnt_next;
  logic [CAUSE_W-1:0] r_irq_cause, w_irq_cause_next;
  logic [XLEN-1:0]    r_resume_pc, w_resume_pc_next;

  logic w_live;
  logic w_in_idle, w_in_drain, w_in_vector;
  logic w_take_exc, w_take_mret, w_take_irq, w_draining;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_mcause_exc, w_mcause_irq;

  // Outputs are forced quiet while reset is asserted.
  assign w_live      = !rst;
  assign w_in_idle   = (r_state == S_IDLE);
  assign w_in_drain  = (r_state == S_DRAIN);
  assign w_in_vector = (r_state == S_VECTOR) && w_live;

  // An exception in M preempts a pending drain; MRET cannot appear in DRAIN
  // because D/E are being flushed, so it is only honoured from IDLE.
  assign w_take_exc  = w_live && bus.exc_valid_M && (w_in_idle || w_in_drain);
  assign w_take_mret = w_live && w_in_idle && bus.mret_M && !bus.exc_valid_M;
  assign w_take_irq  = w_live && w_in_idle && !bus.exc_valid_M && !bus.mret_M &&
                       bus.irq_pending && bus.mie_global;
  assign w_draining  = w_live && w_in_drain && !bus.exc_valid_M;

  // Only the VECTOR cycle computes an interrupt target, so one calculator
  // serves both paths: in any other cycle it yields the plain base.
  trap_target_calc #(
    .XLEN    (XLEN),
    .CAUSE_W (CAUSE_W)
  ) u_target (
    .i_mtvec  (bus.mtvec),
    .i_cause  (r_irq_cause),
    .i_is_irq (w_in_vector),
    .o_target (w_target)
  );

  always_comb begin
    w_mcause_exc = {{(XLEN-CAUSE_W){1'b0}}, bus.exc_cause_M};
    w_mcause_irq = {{(XLEN-CAUSE_W){1'b0}}, r_irq_cause};
    w_mcause_irq[INT_BIT] = 1'b1;
  end

  // Next-state logic
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_irq_cause_next = r_irq_cause;
    w_resume_pc_next = r_resume_pc;
    case (r_state)
      S_IDLE: begin
        if (w_take_irq) begin
          w_state_next     = S_DRAIN;
          w_cnt_next       = 3'd0;
          w_irq_cause_next = bus.irq_cause;
          w_resume_pc_next = bus.resume_pc_M;
        end
      end
      S_DRAIN: begin
        if (w_take_exc) begin
          // Interrupt is dropped; irq_pending is level and will be re-taken.
          w_state_next = S_IDLE;
          w_cnt_next   = 3'd0;
        end else if (r_cnt == DRAIN_LAST) begin
          w_state_next = S_VECTOR;
          w_cnt_next   = 3'd0;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end
      S_VECTOR: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 3'd0;
      r_irq_cause <= '0;
      r_resume_pc <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_irq_cause <= w_irq_cause_next;
      r_resume_pc <= w_resume_pc_next;
    end
  end

  // Output decode
  assign bus.redirect_valid = w_take_exc || w_take_mret || w_in_vector;
  assign bus.redirect_pc    = w_take_mret ? bus.mepc :
                              (w_take_exc || w_in_vector) ? w_target : '0;
  assign bus.stall_F        = w_draining;
  assign bus.flush_D        = w_take_exc || w_take_mret || w_draining;
  assign bus.flush_E        = w_take_exc || w_take_mret || w_draining;
  assign bus.flush_M        = w_take_exc || w_take_mret || w_in_vector;
  assign bus.mepc_we        = w_take_exc || w_in_vector;
  assign bus.mepc_wdata     = w_in_vector ? r_resume_pc :
                              w_take_exc  ? bus.exc_pc_M : '0;
  assign bus.mcause_we      = w_take_exc || w_in_vector;
  assign bus.mcause_wdata   = w_in_vector ? w_mcause_irq :
                              w_take_exc  ? w_mcause_exc : '0;
  assign bus.trap_enter     = w_take_exc || w_in_vector;
  assign bus.trap_exit      = w_take_mret;
  assign bus.busy           = w_live && !w_in_idle;

endmodule

// File: tb/tb_trap_redirect_ctrl.sv
module tb_trap_redirect_ctrl;

  localparam int XLEN    = 32;
  localparam int CAUSE_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  trap_redirect_ctrl_if #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) bus();

  trap_redirect_ctrl #(
    .XLEN         (XLEN),
    .DRAIN_CYCLES (2),
    .CAUSE_W      (CAUSE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef VECTORED_TRAP_EN
  localparam logic [31:0] VEC_IRQ_PC = 32'h0000_012C;
`else
  localparam logic [31:0] VEC_IRQ_PC = 32'h0000_0100;
`endif

  task automatic idle_inputs();
    bus.exc_valid_M = 1'b0;
    bus.exc_cause_M = '0;
    bus.exc_pc_M    = '0;
    bus.mret_M      = 1'b0;
    bus.irq_pending = 1'b0;
    bus.irq_cause   = '0;
    bus.mie_global  = 1'b1;
    bus.mtvec       = 32'h100;
    bus.mepc        = '0;
    bus.resume_pc_M = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %b want 0", bus.redirect_valid); end
    checks++; if (bus.stall_F !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", bus.stall_F); end
    checks++; if (bus.mepc_we !== 1'b0 || bus.mcause_we !== 1'b0) begin errors++; $display("FAIL reset_csr_we: got %b%b want 00", bus.mepc_we, bus.mcause_we); end
    $display("reset: busy=%b redirect=%b", bus.busy, bus.redirect_valid);
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    bus.irq_pending = 1'b1; bus.irq_cause = 5'd11; bus.resume_pc_M = 32'h88;
    @(negedge clk);
    bus.irq_pending = 1'b0; #1;
    checks++; if (bus.stall_F !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL rstdrain_enter: stall=%b busy=%b want 1 1", bus.stall_F, bus.busy); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.mepc_we !== 1'b0 || bus.mcause_we !== 1'b0) begin
        errors++;
        $display("FAIL rstdrain_quiet[%0d]: busy=%b redir=%b mepc_we=%b mcause_we=%b want all 0", i, bus.busy, bus.redirect_valid, bus.mepc_we, bus.mcause_we);
      end
      @(negedge clk);
    end
    $display("reset_mid_drain: done");
  endtask

  task automatic test_exception();
    bus.exc_valid_M = 1'b1; bus.exc_pc_M = 32'h40; bus.exc_cause_M = 5'd2;
    #1;
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL exc_redirect: got %b want 1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h100) begin errors++; $display("FAIL exc_pc: got %h want 00000100", bus.redirect_pc); end
    checks++; if ({bus.flush_D, bus.flush_E, bus.flush_M} !== 3'b111) begin errors++; $display("FAIL exc_flush: got %b want 111", {bus.flush_D, bus.flush_E, bus.flush_M}); end
    checks++; if (bus.mepc_we !== 1'b1 || bus.mepc_wdata !== 32'h40) begin errors++; $display("FAIL exc_mepc: we=%b data=%h want 1 00000040", bus.mepc_we, bus.mepc_wdata); end
    checks++; if (bus.mcause_we !== 1'b1 || bus.mcause_wdata !== 32'h2) begin errors++; $display("FAIL exc_mcause: we=%b data=%h want 1 00000002", bus.mcause_we, bus.mcause_wdata); end
    checks++; if (bus.trap_enter !== 1'b1 || bus.trap_exit !== 1'b0 || bus.stall_F !== 1'b0) begin errors++; $display("FAIL exc_ctrl: enter=%b exit=%b stall=%b want 1 0 0", bus.trap_enter, bus.trap_exit, bus.stall_F); end
    $display("exception: pc=%h mepc=%h mcause=%h", bus.redirect_pc, bus.mepc_wdata, bus.mcause_wdata);
    @(negedge clk);
    idle_inputs(); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL exc_stay_idle: busy=%b want 0", bus.busy); end
    @(negedge clk);
  endtask

  // Accept an interrupt, then measure stall cycles and redirect latency.
  task automatic run_irq(input string tag, input logic [31:0] mtvec_v,
                         input logic [31:0] exp_pc);
    int stalls;
    int found;
    bus.mtvec = mtvec_v;
    bus.irq_pending = 1'b1; bus.irq_cause = 5'd11; bus.resume_pc_M = 32'h88;
    #1;
    checks++; if (bus.redirect_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL %s_accept: redir=%b busy=%b want 0 0", tag, bus.redirect_valid, bus.busy); end
    stalls = 0; found = 0;
    for (int cyc = 1; cyc <= 10 && found == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin bus.irq_pending = 1'b0; bus.resume_pc_M = 32'h0; end
      #1;
      if (bus.stall_F === 1'b1) stalls++;
      if (bus.redirect_valid === 1'b1) found = cyc;
    end
    checks++; if (found != 3) begin errors++; $display("FAIL %s_latency: redirect at cycle %0d want 3", tag, found); end
    checks++; if (stalls != 2) begin errors++; $display("FAIL %s_stalls: got %0d want 2", tag, stalls); end
    checks++; if (bus.redirect_pc !== exp_pc) begin errors++; $display("FAIL %s_pc: got %h want %h", tag, bus.redirect_pc, exp_pc); end
    checks++; if (bus.mepc_we !== 1'b1 || bus.mepc_wdata !== 32'h88) begin errors++; $display("FAIL %s_mepc: we=%b data=%h want 1 00000088", tag, bus.mepc_we, bus.mepc_wdata); end
    checks++; if (bus.mcause_we !== 1'b1 || bus.mcause_wdata !== 32'h8000000B) begin errors++; $display("FAIL %s_mcause: we=%b data=%h want 1 8000000b", tag, bus.mcause_we, bus.mcause_wdata); end
    checks++; if (bus.trap_enter !== 1'b1 || bus.flush_M !== 1'b1) begin errors++; $display("FAIL %s_vector_ctrl: enter=%b flush_M=%b want 1 1", tag, bus.trap_enter, bus.flush_M); end
    $display("%s: redirect cycle=%0d stalls=%0d pc=%h mcause=%h", tag, found, stalls, bus.redirect_pc, bus.mcause_wdata);
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL %s_return: busy=%b redir=%b want 0 0", tag, bus.busy, bus.redirect_valid); end
    idle_inputs();
  endtask

  task automatic test_interrupt();
    run_irq("interrupt", 32'h100, 32'h100);
  endtask

  task automatic test_exc_during_drain();
    bus.irq_pending = 1'b1; bus.irq_cause = 5'd11; bus.resume_pc_M = 32'h88;
    @(negedge clk);
    bus.exc_valid_M = 1'b1; bus.exc_pc_M = 32'h90; bus.exc_cause_M = 5'd11;
    #1;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h100) begin errors++; $display("FAIL drainexc_redirect: v=%b pc=%h want 1 00000100", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.mcause_wdata !== 32'hB || bus.mepc_wdata !== 32'h90) begin errors++; $display("FAIL drainexc_csr: mcause=%h mepc=%h want 0000000b 00000090", bus.mcause_wdata, bus.mepc_wdata); end
    checks++; if (bus.stall_F !== 1'b0 || bus.trap_enter !== 1'b1) begin errors++; $display("FAIL drainexc_ctrl: stall=%b enter=%b want 0 1", bus.stall_F, bus.trap_enter); end
    $display("exc_during_drain: pc=%h mcause=%h", bus.redirect_pc, bus.mcause_wdata);
    @(negedge clk);
    idle_inputs(); #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL drainexc_idle: busy=%b want 0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL drainexc_no_vector[%0d]: redir=%b want 0", i, bus.redirect_valid); end
    end
  endtask

  task automatic test_exc_mret();
    bus.exc_valid_M = 1'b1; bus.exc_pc_M = 32'h44; bus.exc_cause_M = 5'd2;
    bus.mret_M = 1'b1; bus.mepc = 32'h200;
    #1;
    checks++; if (bus.trap_exit !== 1'b0 || bus.trap_enter !== 1'b1) begin errors++; $display("FAIL both_prio: exit=%b enter=%b want 0 1", bus.trap_exit, bus.trap_enter); end
    checks++; if (bus.redirect_pc !== 32'h100 || bus.mcause_we !== 1'b1) begin errors++; $display("FAIL both_pc: pc=%h mcause_we=%b want 00000100 1", bus.redirect_pc, bus.mcause_we); end
    $display("exc+mret: pc=%h exit=%b", bus.redirect_pc, bus.trap_exit);
    @(negedge clk);
    bus.exc_valid_M = 1'b0;
    #1;
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h200) begin errors++; $display("FAIL mret_pc: v=%b pc=%h want 1 00000200", bus.redirect_valid, bus.redirect_pc); end
    checks++; if (bus.trap_exit !== 1'b1 || bus.trap_enter !== 1'b0 || bus.mepc_we !== 1'b0) begin errors++; $display("FAIL mret_ctrl: exit=%b enter=%b mepc_we=%b want 1 0 0", bus.trap_exit, bus.trap_enter, bus.mepc_we); end
    checks++; if ({bus.flush_D, bus.flush_E, bus.flush_M} !== 3'b111) begin errors++; $display("FAIL mret_flush: got %b want 111", {bus.flush_D, bus.flush_E, bus.flush_M}); end
    $display("mret: pc=%h exit=%b", bus.redirect_pc, bus.trap_exit);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_vectored();
    run_irq("vectored", 32'h101, VEC_IRQ_PC);
    @(negedge clk);
    bus.mtvec = 32'h101;
    bus.exc_valid_M = 1'b1; bus.exc_pc_M = 32'h60; bus.exc_cause_M = 5'd11;
    #1;
    checks++; if (bus.redirect_pc !== 32'h100) begin errors++; $display("FAIL vectored_exc_base: pc=%h want 00000100", bus.redirect_pc); end
    $display("vectored exception: pc=%h", bus.redirect_pc);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_mie_off();
    @(negedge clk);
    bus.mie_global = 1'b0; bus.irq_pending = 1'b1; bus.irq_cause = 5'd11;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (bus.busy !== 1'b0 || bus.stall_F !== 1'b0) begin errors++; $display("FAIL mie_off: busy=%b stall=%b want 0 0", bus.busy, bus.stall_F); end
    $display("mie_off: busy=%b", bus.busy);
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_reset_mid_drain();
    test_exception();
    test_interrupt();
    test_exc_during_drain();
    test_exc_mret();
    test_vectored();
    test_mie_off();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
